// File: rtl/wb_pkg.sv
// Shared definitions for the write-back queue: default sizes and entry layout.
package wb_pkg;

    localparam int WB_D_WIDTH = 32;
    localparam int WB_A_WIDTH = 5;
    localparam int WB_DEPTH   = 4;

    // One queued result: destination register and value.
    typedef struct packed {
        logic [WB_A_WIDTH-1:0] addr;
        logic [WB_D_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Per-read-port lookup into the write-back queue: flags a pending write to the
// requested register and, with WB_FORWARD_EN, selects the youngest match's data.
module wb_match #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DEPTH         = 4
`ifdef WB_FORWARD_EN
    ,
    parameter int D_WIDTH       = 32
`endif
) (
    input  logic [ADDRESS_WIDTH-1:0]            rd_addr,
    input  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] ent_addr,
    input  logic [DEPTH-1:0]                    ent_vld,
    input  logic [$clog2(DEPTH)-1:0]            tail,
`ifdef WB_FORWARD_EN
    input  logic [DEPTH-1:0][D_WIDTH-1:0]       ent_data,
    output logic [D_WIDTH-1:0]                  fwd_data,
`endif
    output logic                                hit
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk backwards from the newest slot so the first hit is the youngest entry.
    always_comb begin
        hit = 1'b0;
        idx = '0;
`ifdef WB_FORWARD_EN
        fwd_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = tail - PW'(i + 1);
            if (!hit && ent_vld[idx] && (ent_addr[idx] == rd_addr) && (rd_addr != '0)) begin
                hit = 1'b1;
`ifdef WB_FORWARD_EN
                fwd_data = ent_data[idx];
`endif
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue for multi-cycle unit results: buffers results until the
// register-file write port is free and retires them in acceptance order.
// Optional forwarding of queued data to the read ports: define WB_FORWARD_EN.
module wb_queue
    import wb_pkg::*;
#(
    parameter int D_WIDTH       = WB_D_WIDTH,
    parameter int ADDRESS_WIDTH = WB_A_WIDTH,
    parameter int DEPTH         = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDRESS_WIDTH-1:0]   in_addr,
    input  logic [D_WIDTH-1:0]         in_data,
    input  logic                       wr_block,
    output logic                       wr_en,
    output logic [ADDRESS_WIDTH-1:0]   wr_addr,
    output logic [D_WIDTH-1:0]         din,
    input  logic [ADDRESS_WIDTH-1:0]   rd1_addr,
    input  logic [ADDRESS_WIDTH-1:0]   rd2_addr,
    output logic                       pending1,
    output logic                       pending2,
`ifdef WB_FORWARD_EN
    output logic [D_WIDTH-1:0]         fwd1_data,
    output logic [D_WIDTH-1:0]         fwd2_data,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] ent_addr;
    logic [DEPTH-1:0][D_WIDTH-1:0]       ent_data;
    logic [DEPTH-1:0]                    ent_vld;
    logic [PW-1:0]                       head;
    logic [PW-1:0]                       tail;

    logic empty;
    logic full;
    logic enq;
    logic pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Held low while reset is asserted; full blocks acceptance even if the head pops.
    assign in_ready = rst_n & ~full;
    // Writes to r0 are accepted from the producer but never stored.
    assign enq      = in_valid & in_ready & (in_addr != '0);

    // wr_en depends only on registered occupancy, so a new entry waits one cycle.
    assign wr_en   = ~empty & ~wr_block;
    assign pop     = wr_en;
    assign wr_addr = empty ? '0 : ent_addr[head];
    assign din     = empty ? '0 : ent_data[head];

    // Ring buffer state: push at tail, pop at head, occupancy tracked by count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ent_vld  <= '0;
            ent_addr <= '0;
            ent_data <= '0;
        end else begin
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (enq) begin
                ent_addr[tail] <= in_addr;
                ent_data[tail] <= in_data;
                ent_vld[tail]  <= 1'b1;
                tail           <= tail + 1'b1;
            end
            count <= count + CW'(enq) - CW'(pop);
        end
    end

    logic [1:0][ADDRESS_WIDTH-1:0] rd_addr_v;
    logic [1:0]                    pend_v;
`ifdef WB_FORWARD_EN
    logic [1:0][D_WIDTH-1:0]       fwd_v;
`endif

    assign rd_addr_v = {rd2_addr, rd1_addr};
    assign pending1  = pend_v[0];
    assign pending2  = pend_v[1];
`ifdef WB_FORWARD_EN
    assign fwd1_data = fwd_v[0];
    assign fwd2_data = fwd_v[1];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_port
        wb_match #(
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .DEPTH         (DEPTH)
`ifdef WB_FORWARD_EN
            ,
            .D_WIDTH       (D_WIDTH)
`endif
        ) u_match (
            .rd_addr  (rd_addr_v[g]),
            .ent_addr (ent_addr),
            .ent_vld  (ent_vld),
            .tail     (tail),
`ifdef WB_FORWARD_EN
            .ent_data (ent_data),
            .fwd_data (fwd_v[g]),
`endif
            .hit      (pend_v[g])
        );
    end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: a vector table of per-cycle inputs and expected
// outputs, followed by a hand-written reset-during-drain sequence.
// Forwarding outputs are compared only when WB_FORWARD_EN is defined.
module tb_wb_queue;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wr_block;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] din;
    logic [4:0]  rd1_addr;
    logic [4:0]  rd2_addr;
    logic        pending1;
    logic        pending2;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_queue #(.D_WIDTH(32), .ADDRESS_WIDTH(5), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .wr_block  (wr_block),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .din       (din),
        .rd1_addr  (rd1_addr),
        .rd2_addr  (rd2_addr),
        .pending1  (pending1),
        .pending2  (pending2),
`ifdef WB_FORWARD_EN
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data),
`endif
        .count     (count)
    );

`ifndef WB_FORWARD_EN
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

    typedef struct {
        logic        v;
        wb_entry_t   ent;
        logic        blk;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_wen;
        logic [4:0]  e_wa;
        logic [31:0] e_din;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_p1;
        logic        e_p2;
        logic [31:0] e_f1;
        logic [31:0] e_f2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic blk, input logic [4:0] r1, input logic [4:0] r2,
                       input logic wen, input logic [4:0] wa, input logic [31:0] dn,
                       input logic [2:0] cnt, input logic rdy, input logic p1,
                       input logic p2, input logic [31:0] f1, input logic [31:0] f2);
        vec_t t;
        t.v = v; t.ent.addr = a; t.ent.data = d; t.blk = blk; t.r1 = r1; t.r2 = r2;
        t.e_wen = wen; t.e_wa = wa; t.e_din = dn; t.e_cnt = cnt; t.e_rdy = rdy;
        t.e_p1 = p1; t.e_p2 = p2; t.e_f1 = f1; t.e_f2 = f2;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        wr_block = 1'b0; rd1_addr = 5'd3; rd2_addr = 5'd3;

        // v      a   d        blk r1 r2 | wen wa din      cnt rdy p1 p2 f1       f2
        add(0,  0, 0,        0,  0, 0,   0,  0, 0,       0,  1,  0, 0, 0,       0);
        add(1,  5, 'hAAAA,   0,  0, 0,   0,  0, 0,       0,  1,  0, 0, 0,       0);
        add(0,  0, 0,        0,  5, 0,   1,  5, 'hAAAA,  1,  1,  1, 0, 'hAAAA,  0);
        add(0,  0, 0,        0,  5, 0,   0,  0, 0,       0,  1,  0, 0, 0,       0);
        add(1,  0, 'h1234,   0,  0, 0,   0,  0, 0,       0,  1,  0, 0, 0,       0);
        add(0,  0, 0,        0,  0, 0,   0,  0, 0,       0,  1,  0, 0, 0,       0);
        add(1,  3, 'h11,     1,  0, 0,   0,  0, 0,       0,  1,  0, 0, 0,       0);
        add(1,  3, 'h22,     1,  3, 0,   0,  3, 'h11,    1,  1,  1, 0, 'h11,    0);
        add(0,  0, 0,        1,  3, 0,   0,  3, 'h11,    2,  1,  1, 0, 'h22,    0);
        add(1,  7, 'h33,     1,  0, 7,   0,  3, 'h11,    2,  1,  0, 0, 0,       0);
        add(1,  9, 'h44,     1,  0, 7,   0,  3, 'h11,    3,  1,  0, 1, 0,       'h33);
        add(1, 10, 'h55,     1,  0, 0,   0,  3, 'h11,    4,  0,  0, 0, 0,       0);
        add(0,  0, 0,        0,  0, 0,   1,  3, 'h11,    4,  0,  0, 0, 0,       0);
        add(0,  0, 0,        0,  0, 0,   1,  3, 'h22,    3,  1,  0, 0, 0,       0);
        add(0,  0, 0,        0,  0, 0,   1,  7, 'h33,    2,  1,  0, 0, 0,       0);
        add(0,  0, 0,        0,  0, 0,   1,  9, 'h44,    1,  1,  0, 0, 0,       0);
        add(0,  0, 0,        0,  0, 0,   0,  0, 0,       0,  1,  0, 0, 0,       0);
        add(1,  4, 'h66,     0,  0, 0,   0,  0, 0,       0,  1,  0, 0, 0,       0);
        add(1,  6, 'h77,     0,  0, 0,   1,  4, 'h66,    1,  1,  0, 0, 0,       0);
        add(0,  0, 0,        0,  6, 0,   1,  6, 'h77,    1,  1,  1, 0, 'h77,    0);
        add(0,  0, 0,        0,  0, 0,   0,  0, 0,       0,  1,  0, 0, 0,       0);
        add(1,  1, 1,        1,  0, 0,   0,  0, 0,       0,  1,  0, 0, 0,       0);
        add(1,  2, 2,        1,  0, 0,   0,  1, 1,       1,  1,  0, 0, 0,       0);
        add(1,  3, 3,        1,  0, 0,   0,  1, 1,       2,  1,  0, 0, 0,       0);
        add(1,  4, 4,        1,  0, 0,   0,  1, 1,       3,  1,  0, 0, 0,       0);
        add(1,  8, 'h88,     0,  0, 0,   1,  1, 1,       4,  0,  0, 0, 0,       0);
        add(0,  0, 0,        1,  0, 0,   0,  2, 2,       3,  1,  0, 0, 0,       0);

        // Reset values while rst_n is held low.
        #3;
        chk("rst count",    32'(count),    0);
        chk("rst in_ready", 32'(in_ready), 0);
        chk("rst wr_en",    32'(wr_en),    0);
        chk("rst wr_addr",  32'(wr_addr),  0);
        chk("rst din",      din,           0);
        chk("rst pending1", 32'(pending1), 0);
        chk("rst pending2", 32'(pending2), 0);
        chk("rst fwd1",     fwd1_data,     0);

        @(negedge clk);
        rst_n = 1'b1; rd1_addr = '0; rd2_addr = '0;
        #1;
        chk("post-rst in_ready", 32'(in_ready), 1);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            in_valid = vecs[k].v;
            in_addr  = vecs[k].ent.addr;
            in_data  = vecs[k].ent.data;
            wr_block = vecs[k].blk;
            rd1_addr = vecs[k].r1;
            rd2_addr = vecs[k].r2;
            #1;
            chk($sformatf("v%0d wr_en", k),    32'(wr_en),    32'(vecs[k].e_wen));
            chk($sformatf("v%0d wr_addr", k),  32'(wr_addr),  32'(vecs[k].e_wa));
            chk($sformatf("v%0d din", k),      din,           vecs[k].e_din);
            chk($sformatf("v%0d count", k),    32'(count),    32'(vecs[k].e_cnt));
            chk($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(vecs[k].e_rdy));
            chk($sformatf("v%0d pending1", k), 32'(pending1), 32'(vecs[k].e_p1));
            chk($sformatf("v%0d pending2", k), 32'(pending2), 32'(vecs[k].e_p2));
`ifdef WB_FORWARD_EN
            chk($sformatf("v%0d fwd1", k),     fwd1_data,     vecs[k].e_f1);
            chk($sformatf("v%0d fwd2", k),     fwd2_data,     vecs[k].e_f2);
`endif
        end

        // Three entries (2,3,4) remain; release the port, then reset mid-cycle.
        @(negedge clk);
        in_valid = 1'b0; wr_block = 1'b0; rd1_addr = 5'd3;
        #1;
        chk("drain wr_en",    32'(wr_en),    1);
        chk("drain wr_addr",  32'(wr_addr),  2);
        chk("drain pending1", 32'(pending1), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid-rst wr_en",    32'(wr_en),    0);
        chk("mid-rst count",    32'(count),    0);
        chk("mid-rst in_ready", 32'(in_ready), 0);
        chk("mid-rst wr_addr",  32'(wr_addr),  0);
        chk("mid-rst din",      din,           0);
        chk("mid-rst pending1", 32'(pending1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel in_ready", 32'(in_ready), 1);
        chk("rel count",    32'(count),    0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rel c%0d wr_en", c), 32'(wr_en),    0);
            chk($sformatf("rel c%0d count", c), 32'(count),    0);
            chk($sformatf("rel c%0d pend1", c), 32'(pending1), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
